if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 159 +++++++++++++++
 tb/tb_if_id_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Pipeline register between instruction fetch and decode, built as a
// two-entry skid buffer (head + skid) with valid/ready handshakes on both
// sides. The head entry is presented to decode; the skid entry absorbs one
// extra instruction so fetch can keep streaming while decode is stalled.
//
// Optional feature: define IFID_STALL_CNT_EN to enable a saturating counter
// of cycles in which fetch offered an instruction that could not be accepted.
// With the macro undefined, stall_cnt is tied to zero.
//
// Ports:
//   clk           rising-edge clock
//   resetn        synchronous active-low reset
//   in_valid      fetch presents an instruction
//   in_ready      stage can accept an instruction this cycle
//   in_pc         PC of the fetched instruction
//   in_inst       fetched instruction word
//   flush         discard all held instructions (redirect)
//   out_valid     decode is presented an instruction
//   out_ready     decode accepts the presented instruction
//   out_pc        PC of the head instruction (0 when empty)
//   out_inst      head instruction word (0 when empty)
//   out_pc_plus4  out_pc + 4, modulo 2^32 (0 when empty)
//   stall_cnt     input-stall cycle counter (0 unless IFID_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module if_id_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_t;

    count_t      count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic push;
    logic pop;

    // in_ready looks only at registered occupancy and flush so that fetch
    // never sees a combinational path from out_ready.
    assign in_ready  = (count_q != TWO) && !flush;
    assign out_valid = (count_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A popped head register keeps its stale contents, so the outputs are
    // masked to present a clean bubble whenever the stage is empty.
    assign out_pc       = out_valid ? head_pc_q : 32'd0;
    assign out_inst     = out_valid ? head_inst_q : 32'd0;
    assign out_pc_plus4 = out_valid ? (head_pc_q + 32'd4) : 32'd0;

    always_comb begin
        count_d     = count_q;
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        case (count_q)
            EMPTY: begin
                if (push) begin
                    head_pc_d   = in_pc;
                    head_inst_d = in_inst;
                    count_d     = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new instruction replaces it directly.
                    head_pc_d   = in_pc;
                    head_inst_d = in_inst;
                end else if (push) begin
                    skid_pc_d   = in_pc;
                    skid_inst_d = in_inst;
                    count_d     = TWO;
                end else if (pop) begin
                    count_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_pc_d   = skid_pc_q;
                    head_inst_d = skid_inst_q;
                    count_d     = ONE;
                end
            end
            default: begin
                count_d = EMPTY;
            end
        endcase

        // A redirect drops everything, whatever else happened this cycle.
        if (flush) begin
            count_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q     <= EMPTY;
            head_pc_q   <= 32'd0;
            head_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
        end else begin
            count_q     <= count_d;
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where fetch offered an instruction that was refused;
    // holds at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed self-checking bench for if_id_stage. Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point, so every
// check sees the state settled by the preceding edge.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus4;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    if_id_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_pc_plus4 (out_pc_plus4),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stall counter values depend on whether the feature is built.
`ifdef IFID_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    function automatic logic [31:0] exp_stall(input logic [31:0] n);
        return STALL_EN ? n : 32'd0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs; they take effect at the next rising edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] pc,
                                  input logic [31:0] inst, input logic ordy,
                                  input logic fl, input logic rstn);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        resetn    = rstn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the head entry presented to decode.
    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst);
        check_output({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_output({tag, "_pc"}, out_pc, pc);
        check_output({tag, "_inst"}, out_inst, inst);
        check_output({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
    endtask

    task automatic check_bubble(input string tag);
        check_output({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_output({tag, "_pc"}, out_pc, 32'd0);
        check_output({tag, "_inst"}, out_inst, 32'd0);
        check_output({tag, "_pc4"}, out_pc_plus4, 32'd0);
    endtask

    initial begin
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset then idle.
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_bubble("rst");
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_stall", stall_cnt, 32'd0);

        // Streaming with decode always ready: one-cycle latency, no stalls.
        apply_stimulus(1'b1, 32'h100, 32'hA000_0100, 1'b1, 1'b0, 1'b1);
        step();
        check_head("s0", 32'h100, 32'hA000_0100);
        check_output("s0_pc4_abs", out_pc_plus4, 32'h104);
        check_output("s0_in_ready", {31'd0, in_ready}, 32'd1);
        apply_stimulus(1'b1, 32'h104, 32'hA000_0104, 1'b1, 1'b0, 1'b1);
        step();
        check_head("s1", 32'h104, 32'hA000_0104);
        check_output("s1_pc4_abs", out_pc_plus4, 32'h108);
        check_output("s1_in_ready", {31'd0, in_ready}, 32'd1);
        apply_stimulus(1'b1, 32'h108, 32'hA000_0108, 1'b1, 1'b0, 1'b1);
        step();
        check_head("s2", 32'h108, 32'hA000_0108);
        check_output("s2_pc4_abs", out_pc_plus4, 32'h10C);
        check_output("s2_in_ready", {31'd0, in_ready}, 32'd1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        check_bubble("s_drain");

        // Decode stalled: fill both entries, then drain in order.
        apply_stimulus(1'b1, 32'h200, 32'hB000_0200, 1'b0, 1'b0, 1'b1);
        step();
        check_head("f0", 32'h200, 32'hB000_0200);
        check_output("f0_in_ready", {31'd0, in_ready}, 32'd1);
        apply_stimulus(1'b1, 32'h204, 32'hB000_0204, 1'b0, 1'b0, 1'b1);
        step();
        check_head("f1", 32'h200, 32'hB000_0200);
        check_output("f1_in_ready_full", {31'd0, in_ready}, 32'd0);
        // Third instruction offered while full; held until it is accepted.
        apply_stimulus(1'b1, 32'h208, 32'hB000_0208, 1'b1, 1'b0, 1'b1);
        step();
        check_head("d0", 32'h204, 32'hB000_0204);
        check_output("d0_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("d0_stall", stall_cnt, exp_stall(32'd1));
        apply_stimulus(1'b1, 32'h208, 32'hB000_0208, 1'b1, 1'b0, 1'b1);
        step();
        check_head("d1", 32'h208, 32'hB000_0208);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        check_bubble("d2");
        check_output("d2_stall", stall_cnt, exp_stall(32'd1));

        // Flush while full, with a simultaneous offered instruction.
        apply_stimulus(1'b1, 32'h2F0, 32'hC000_02F0, 1'b0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b1, 32'h2F4, 32'hC000_02F4, 1'b0, 1'b0, 1'b1);
        step();
        check_head("fl_full", 32'h2F0, 32'hC000_02F0);
        apply_stimulus(1'b1, 32'h300, 32'hC000_0300, 1'b0, 1'b1, 1'b1);
        #1;
        check_output("fl_in_ready_flush", {31'd0, in_ready}, 32'd0);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_bubble("fl0");
        check_output("fl0_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("fl0_stall", stall_cnt, exp_stall(32'd2));
        step();
        check_bubble("fl1");

        // PC wrap on the +4 adder.
        apply_stimulus(1'b1, 32'hFFFF_FFFC, 32'hD000_0000, 1'b0, 1'b0, 1'b1);
        step();
        check_output("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check_output("wrap_pc4", out_pc_plus4, 32'h0000_0000);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        check_bubble("wrap_drain");

        // Reset while full; an offered instruction during reset is ignored.
        apply_stimulus(1'b1, 32'h3A0, 32'hE000_03A0, 1'b0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b1, 32'h3A4, 32'hE000_03A4, 1'b0, 1'b0, 1'b1);
        step();
        check_output("r_full_in_ready", {31'd0, in_ready}, 32'd0);
        apply_stimulus(1'b1, 32'h3FC, 32'hE000_03FC, 1'b1, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_bubble("r0");
        check_output("r0_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("r0_stall", stall_cnt, 32'd0);
        apply_stimulus(1'b1, 32'h400, 32'hF000_0400, 1'b0, 1'b0, 1'b1);
        step();
        check_head("r1", 32'h400, 32'hF000_0400);
        check_output("r1_stall", stall_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
